rf_wb_arbiter: RTL and testbench

//   Shares the single write port of reg_file between two writeback sources:
//   A = main single-cycle datapath (priority, no handshake) and B = long-latency

---
 rtl/rf_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single reg_file write port: the datapath (A) has priority,
// the long-latency unit (B) drains through a FIFO, and a pending-write scoreboard drives stall.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_we,
    input  logic [4:0]               a_wa,
    input  logic [31:0]              a_wd,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_wa,
    input  logic [31:0]              b_wd,
    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd,
    output logic                     iss_ready,
    input  logic [4:0]               chk_rs,
    input  logic [4:0]               chk_rt,
    input  logic [4:0]               chk_rd,
    output logic                     stall,
    output logic                     rf_we,
    output logic [4:0]               rf_wa,
    output logic [31:0]              rf_wd,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STARVE_MAX) + 1;
    localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

    logic [4:0]    wa_mem [DEPTH];
    logic [31:0]   wd_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;

    logic          empty, full, push, pop, a_own, sel_v;
    logic [4:0]    sel_wa, head_wa;
    logic [31:0]   sel_wd, head_wd, set_mask, clr_mask;

    assign empty      = (count_q == '0);
    assign full       = (count_q == (PW+1)'(DEPTH));
    assign b_ready    = ~full;
    assign push       = b_valid & ~full;
    assign head_wa    = wa_mem[rd_ptr_q];
    assign head_wd    = wd_mem[rd_ptr_q];
    assign fifo_count = count_q;

    always_comb begin
        pop    = 1'b0;
        a_own  = 1'b0;
        sel_v  = 1'b0;
        sel_wa = '0;
        sel_wd = '0;
        if (hold_q) begin
            pop    = ~empty;
            sel_v  = ~empty;
            sel_wa = head_wa;
            sel_wd = head_wd;
        end else if (a_we) begin
            a_own  = 1'b1;
            sel_v  = 1'b1;
            sel_wa = a_wa;
            sel_wd = a_wd;
        end else if (!empty) begin
            pop    = 1'b1;
            sel_v  = 1'b1;
            sel_wa = head_wa;
            sel_wd = head_wd;
        end
    end

    // Reset forces the port quiet even while A is still requesting.
    assign rf_we = ~rst & sel_v & (sel_wa != '0);
    assign rf_wa = rst ? '0 : sel_wa;
    assign rf_wd = rst ? '0 : sel_wd;

    assign stall = hold_q
                 | ((chk_rs != '0) & busy_q[chk_rs])
                 | ((chk_rt != '0) & busy_q[chk_rt])
                 | ((chk_rd != '0) & busy_q[chk_rd]);
    assign iss_ready = ~busy_q[iss_rd] & ~stall;

    assign set_mask = (iss_valid & iss_ready & (iss_rd != '0)) ? (32'd1 << iss_rd) : '0;
    assign clr_mask = (pop & (head_wa != '0)) ? (32'd1 << head_wa) : '0;

    always_comb begin
        busy_d   = (busy_q & ~clr_mask) | set_mask;
        wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        starve_d = starve_q;
        hold_d   = 1'b0;
        // Only a cycle where A wins over a non-empty FIFO advances the starvation count.
        if (pop || empty) begin
            starve_d = '0;
        end else if (a_own) begin
            hold_d   = (starve_q == STARVE_LAST);
            starve_d = (starve_q == STARVE_LAST) ? starve_q : starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wa_mem[wr_ptr_q] <= b_wa;
            wd_mem[wr_ptr_q] <= b_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue/array reference model predicts every
// port write and status output; a negedge monitor compares them against the DUT.
module tb_rf_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  chk_rs, chk_rt, chk_rd;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [2:0]  fifo_count;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
        .stall(stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    // Reference model state
    wr_t       fifo_m[$];
    bit [31:0] busy_m;
    int        a_run_m;   // consecutive cycles A has beaten a waiting FIFO
    bit        hold_m;

    // Predictions for the current cycle
    wr_t exp_q[$];
    bit  exp_we, exp_stall, exp_bready, exp_issready;
    int  exp_count;
    bit  d_pop, d_push, d_iss, d_aown;
    bit  in_reset = 1'b0;
    bit  done = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic compute_expect();
        wr_t w;
        bit  have;
        have      = 1'b0;
        d_pop     = 1'b0;
        d_aown    = 1'b0;
        exp_stall = hold_m || (chk_rs != 0 && busy_m[chk_rs]) ||
                    (chk_rt != 0 && busy_m[chk_rt]) || (chk_rd != 0 && busy_m[chk_rd]);
        exp_bready   = fifo_m.size() < DEPTH;
        exp_issready = !busy_m[iss_rd] && !exp_stall;
        exp_count    = fifo_m.size();
        if (hold_m || (!a_we && fifo_m.size() > 0)) begin
            w     = fifo_m[0];
            have  = 1'b1;
            d_pop = 1'b1;
        end else if (a_we) begin
            w      = wr_t'{wa: a_wa, wd: a_wd};
            have   = 1'b1;
            d_aown = 1'b1;
        end
        exp_we = have && (w.wa != 0);
        if (exp_we) exp_q.push_back(w);
        d_push = b_valid && exp_bready;
        d_iss  = iss_valid && exp_issready && iss_rd != 0;
    endtask

    task automatic model_update();
        wr_t h;
        bit  had_entries;
        had_entries = fifo_m.size() > 0;
        if (d_pop) begin
            h = fifo_m.pop_front();
            busy_m[h.wa] = 1'b0;
        end
        if (d_iss) busy_m[iss_rd] = 1'b1;
        busy_m[0] = 1'b0;
        if (d_push) fifo_m.push_back(wr_t'{wa: b_wa, wd: b_wd});
        hold_m = 1'b0;
        if (d_pop || !had_entries) begin
            a_run_m = 0;
        end else if (d_aown) begin
            a_run_m++;
            if (a_run_m == STARVE_MAX) hold_m = 1'b1;
        end
    endtask

    task automatic tick();
        compute_expect();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        in_reset = 1'b1;
        fifo_m.delete();
        exp_q.delete();
        busy_m = '0;
        a_run_m = 0;
        hold_m = 1'b0;
        exp_we = 1'b0;
        exp_stall = 1'b0;
        exp_bready = 1'b1;
        exp_issready = 1'b1;
        exp_count = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic idle_inputs();
        a_we = 0; a_wa = 0; a_wd = 0;
        b_valid = 0; b_wa = 0; b_wd = 0;
        iss_valid = 0; iss_rd = 0;
        chk_rs = 0; chk_rt = 0; chk_rd = 0;
    endtask

    // Monitor: the only process that touches the check counters
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        wr_t w;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            chk("stall", 64'(stall), 64'(exp_stall));
            chk("b_ready", 64'(b_ready), 64'(exp_bready));
            chk("iss_ready", 64'(iss_ready), 64'(exp_issready));
            chk("fifo_count", 64'(fifo_count), 64'(exp_count));
            chk("rf_we", 64'(rf_we), 64'(exp_we));
            if (in_reset) begin
                chk("rf_wa_reset", 64'(rf_wa), 64'd0);
                chk("rf_wd_reset", 64'(rf_wd), 64'd0);
            end
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_wa", 64'(rf_wa), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("rf_wa", 64'(rf_wa), 64'(w.wa));
                    chk("rf_wd", 64'(rf_wd), 64'(w.wd));
                end
            end else if (exp_we && exp_q.size() > 0) begin
                w = exp_q.pop_front();
            end
        end
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int n;
        int guard;
        bit pending;
        idle_inputs();
        apply_reset(2);

        // A-only write
        a_we = 1; a_wa = 5'd1; a_wd = 32'hDEADBEEF;
        tick();
        a_we = 0;
        tick();

        // Issue to r5, B result returns while A idle; stall tracks busy[5]
        iss_valid = 1; iss_rd = 5'd5;
        tick();
        iss_valid = 0; chk_rs = 5'd5;
        b_valid = 1; b_wa = 5'd5; b_wd = 32'h12345678;
        tick();
        b_valid = 0;
        repeat (3) tick();
        chk_rs = 0;

        // FIFO fill under continuous A traffic, fifth result held until a forced drain
        n = 0; guard = 0;
        a_we = 1;
        while (n < 5 && guard < 30) begin
            a_wa = 5'(1 + (guard % 30)); a_wd = 32'hA000_0000 + guard;
            b_valid = 1; b_wa = 5'(10 + n); b_wd = 32'hB000_0000 + n;
            tick();
            if (d_push) n++;
            guard++;
        end
        b_valid = 0;
        repeat (12) tick();
        a_we = 0;
        repeat (6) tick();

        // Zero register on both sources, issue to r0
        a_we = 1; a_wa = 0; a_wd = 32'h1111_1111;
        tick();
        a_we = 0;
        b_valid = 1; b_wa = 0; b_wd = 32'h2222_2222;
        tick();
        b_valid = 0;
        iss_valid = 1; iss_rd = 0;
        tick();
        iss_valid = 0;
        repeat (2) tick();

        // Reset mid-operation: three queued results plus busy[7], A still requesting
        a_we = 1; a_wa = 5'd3; a_wd = 32'h3333_3333;
        iss_valid = 1; iss_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1; b_wa = 5'(20 + i); b_wd = 32'hC000_0000 + i;
            tick();
            iss_valid = 0;
        end
        b_valid = 0;
        apply_reset(1);
        a_we = 0; chk_rd = 5'd7; iss_rd = 5'd7;
        tick();
        idle_inputs();
        tick();

        // Randomized traffic with B results held until accepted
        pending = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset($urandom_range(1, 2));
                pending = 1'b0;
            end
            a_we = ($urandom_range(0, 1) == 1);
            a_wa = 5'($urandom_range(0, 9));
            a_wd = $urandom;
            if (!pending) begin
                b_valid = ($urandom_range(0, 9) < 4);
                b_wa = 5'($urandom_range(0, 9));
                b_wd = $urandom;
            end
            iss_valid = ($urandom_range(0, 9) < 3);
            iss_rd = 5'($urandom_range(0, 9));
            chk_rs = 5'($urandom_range(0, 9));
            chk_rt = 5'($urandom_range(0, 9));
            chk_rd = 5'($urandom_range(0, 9));
            tick();
            pending = b_valid && !d_push;
        end

        idle_inputs();
        repeat (10) tick();
        done = 1'b1;
    end
endmodule
